// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver and its companion
// transmitter.
//   state_t  : one-hot FSM state encodings
//   PAR_EVEN : parity mode selector value for even parity
//   PAR_ODD  : parity mode selector value for odd parity
package uart_rx_cfg_pkg;

    typedef enum logic [6:0] {
        IDLE      = 7'b000_0001,
        START     = 7'b000_0010,
        DATA      = 7'b000_0100,
        PARITY    = 7'b000_1000,
        STOP      = 7'b001_0000,
        EMIT      = 7'b010_0000,
        WAIT_IDLE = 7'b100_0000
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_cfg_sync2.sv
// Two-flop synchroniser for asynchronous inputs.
//   clk      : destination clock
//   reset    : synchronous, active-high; loads RESET_VAL into both stages
//   async_in : asynchronous input
//   sync_out : synchronised output, two clocks of latency
module uart_rx_cfg_sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta     <= RESET_VAL;
            sync_out <= RESET_VAL;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: NB_DATA data bits (LSB first), optional
// even/odd parity, 1 or 2 stop bits, mid-bit sampling from an oversampling
// tick.
//   i_clk        : system clock
//   i_reset      : synchronous, active-high reset
//   i_tick       : one-cycle enable at baud * N_OVERSAMPLE
//   i_rx_data    : asynchronous serial line, idle high
//   o_data       : last received word, held until the next o_valid
//   o_valid      : one-cycle pulse per completed frame
//   o_parity_err : parity mismatch, qualified by o_valid
//   o_frame_err  : a stop bit sampled low, qualified by o_valid
//   o_busy       : high whenever the FSM is not in IDLE
//
// state     | meaning
// IDLE      | line idle, waiting for a low sample on a tick
// START     | timing to the middle of the start bit, glitch rejection
// DATA      | sampling NB_DATA data bits at mid-bit
// PARITY    | sampling the parity bit
// STOP      | sampling NB_STOP stop bits
// EMIT      | one clock, o_valid high with word and error flags
// WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int NB_DATA      = 8,
    parameter int N_OVERSAMPLE = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int NB_STOP      = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int TW = $clog2(N_OVERSAMPLE);
    localparam int BW = $clog2(NB_DATA + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(N_OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(N_OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(NB_STOP - 1);
    localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    state_t               state, state_next;
    logic [TW-1:0]        tick_cnt, tick_cnt_next;
    logic [BW-1:0]        bit_cnt, bit_cnt_next;
    logic [NB_DATA-1:0]   shreg, shreg_next;
    logic [NB_DATA-1:0]   data_q, data_next;
    logic                 par_latch, par_latch_next;
    logic                 frm_latch, frm_latch_next;
    logic                 perr_q, perr_next;
    logic                 ferr_q, ferr_next;
    logic                 rxs;
    logic                 mid_bit;

    uart_rx_cfg_sync2 #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk      (i_clk),
        .reset    (i_reset),
        .async_in (i_rx_data),
        .sync_out (rxs)
    );

    assign mid_bit = i_tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data_q    <= '0;
            par_latch <= 1'b0;
            frm_latch <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_cnt_next;
            bit_cnt   <= bit_cnt_next;
            shreg     <= shreg_next;
            data_q    <= data_next;
            par_latch <= par_latch_next;
            frm_latch <= frm_latch_next;
            perr_q    <= perr_next;
            ferr_q    <= ferr_next;
        end
    end

    // Word and flags are loaded on the final stop sample so they are already
    // stable in the EMIT cycle, where o_valid is high; the flags clear as EMIT
    // is left.
    always_comb begin
        state_next     = state;
        tick_cnt_next  = tick_cnt;
        bit_cnt_next   = bit_cnt;
        shreg_next     = shreg;
        data_next      = data_q;
        par_latch_next = par_latch;
        frm_latch_next = frm_latch;
        perr_next      = 1'b0;
        ferr_next      = 1'b0;

        case (state)
            IDLE: begin
                if (i_tick && !rxs) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (tick_cnt == TICK_MID) begin
                        if (rxs) begin
                            state_next = IDLE;
                        end else begin
                            state_next    = DATA;
                            tick_cnt_next = '0;
                            bit_cnt_next  = '0;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + TW'(1);
                    end
                end
            end
            DATA: begin
                if (mid_bit) begin
                    tick_cnt_next = '0;
                    for (int i = 0; i < NB_DATA; i++) begin
                        if (bit_cnt == BW'(i)) shreg_next[i] = rxs;
                    end
                    bit_cnt_next = bit_cnt + BW'(1);
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end else if (i_tick) begin
                    tick_cnt_next = tick_cnt + TW'(1);
                end
            end
            PARITY: begin
                if (mid_bit) begin
                    tick_cnt_next  = '0;
                    bit_cnt_next   = '0;
                    par_latch_next = ((^shreg) ^ rxs) != PAR_MODE;
                    state_next     = STOP;
                end else if (i_tick) begin
                    tick_cnt_next = tick_cnt + TW'(1);
                end
            end
            STOP: begin
                if (mid_bit) begin
                    tick_cnt_next = '0;
                    if (!rxs) frm_latch_next = 1'b1;
                    bit_cnt_next = bit_cnt + BW'(1);
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_next   = '0;
                        state_next     = EMIT;
                        data_next      = shreg;
                        perr_next      = par_latch;
                        ferr_next      = frm_latch | ~rxs;
                        par_latch_next = 1'b0;
                        frm_latch_next = 1'b0;
                    end
                end else if (i_tick) begin
                    tick_cnt_next = tick_cnt + TW'(1);
                end
            end
            EMIT: begin
                // A framing error usually means a break; hold off until the
                // line is seen high so a held-low line yields one frame only.
                state_next = ferr_q ? WAIT_IDLE : IDLE;
            end
            WAIT_IDLE: begin
                if (i_tick && rxs) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_data       = data_q;
    assign o_valid      = (state == EMIT);
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

    localparam int CPB_A = 64;  // 16 ticks per bit, tick every 4 clocks
    localparam int CPB_B = 8;   // 8 ticks per bit, tick every clock

    logic clk;
    logic reset;
    logic tick_a, tick_b;
    logic rx_a, rx_p, rx_b;

    logic [7:0] data_a, data_p;
    logic [6:0] data_b;
    logic valid_a, perr_a, ferr_a, busy_a;
    logic valid_p, perr_p, ferr_p, busy_p;
    logic valid_b, perr_b, ferr_b, busy_b;

    int n_chk  = 0;
    int n_pass = 0;

    uart_rx_cfg dut_a (
        .i_clk(clk), .i_reset(reset), .i_tick(tick_a), .i_rx_data(rx_a),
        .o_data(data_a), .o_valid(valid_a), .o_parity_err(perr_a),
        .o_frame_err(ferr_a), .o_busy(busy_a)
    );

    uart_rx_cfg #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .i_clk(clk), .i_reset(reset), .i_tick(tick_a), .i_rx_data(rx_p),
        .o_data(data_p), .o_valid(valid_p), .o_parity_err(perr_p),
        .o_frame_err(ferr_p), .o_busy(busy_p)
    );

    uart_rx_cfg #(.NB_DATA(7), .N_OVERSAMPLE(8), .NB_STOP(2)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_tick(tick_b), .i_rx_data(rx_b),
        .o_data(data_b), .o_valid(valid_b), .o_parity_err(perr_b),
        .o_frame_err(ferr_b), .o_busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick_a = 1'b0;
        forever begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                tick_a = (k == 3);
            end
        end
    end

    // Capture of completed frames, sampled mid-cycle.
    int         nv_a = 0, nv_p = 0, nv_b = 0;
    int         busy_cyc_a = 0;
    int         err_cnt_b = 0;
    logic [7:0] ld_a, ld_p;
    logic       lpe_a, lfe_a, lpe_p, lfe_p, lfe_b;
    logic [6:0] log_b [0:15];

    always @(negedge clk) begin
        if (busy_a === 1'b1) busy_cyc_a++;
        if (valid_a === 1'b1) begin
            ld_a = data_a; lpe_a = perr_a; lfe_a = ferr_a; nv_a++;
        end
        if (valid_p === 1'b1) begin
            ld_p = data_p; lpe_p = perr_p; lfe_p = ferr_p; nv_p++;
        end
        if (valid_b === 1'b1) begin
            if (nv_b < 16) log_b[nv_b] = data_b;
            lfe_b = ferr_b;
            if (perr_b || ferr_b) err_cnt_b++;
            nv_b++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int which, input int nbits, input logic [15:0] bits, input int cpb);
        for (int i = 0; i < nbits; i++) begin
            case (which)
                0:       rx_a = bits[i];
                1:       rx_p = bits[i];
                default: rx_b = bits[i];
            endcase
            repeat (cpb) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_a = 1'b1; rx_p = 1'b1; rx_b = 1'b1;
        idle(4); #1;
        n_chk++; if (data_a !== 8'h00) $display("FAIL reset_data_a got %h exp 00", data_a); else n_pass++;
        n_chk++; if (valid_a !== 1'b0) $display("FAIL reset_valid_a got %b exp 0", valid_a); else n_pass++;
        n_chk++; if (perr_a !== 1'b0 || ferr_a !== 1'b0) $display("FAIL reset_err_a got %b%b exp 00", perr_a, ferr_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL reset_busy_a got %b exp 0", busy_a); else n_pass++;
        n_chk++; if (busy_p !== 1'b0) $display("FAIL reset_busy_p got %b exp 0", busy_p); else n_pass++;
        n_chk++; if (data_b !== 7'h00) $display("FAIL reset_data_b got %h exp 00", data_b); else n_pass++;
        n_chk++; if (valid_b !== 1'b0) $display("FAIL reset_valid_b got %b exp 0", valid_b); else n_pass++;
        idle(1);
        reset = 1'b0;
        idle(8);
    endtask

    task automatic test_basic();
        int n0;
        n0 = nv_a;
        send(0, 10, 16'({1'b1, 8'hA5, 1'b0}), CPB_A);
        idle(CPB_A); #1;
        n_chk++; if (nv_a - n0 !== 1) $display("FAIL basic_count got %0d exp 1", nv_a - n0); else n_pass++;
        n_chk++; if (ld_a !== 8'hA5) $display("FAIL basic_data got %h exp a5", ld_a); else n_pass++;
        n_chk++; if (lpe_a !== 1'b0) $display("FAIL basic_perr got %b exp 0", lpe_a); else n_pass++;
        n_chk++; if (lfe_a !== 1'b0) $display("FAIL basic_ferr got %b exp 0", lfe_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL basic_busy_after got %b exp 0", busy_a); else n_pass++;
    endtask

    task automatic test_parity();
        int n0;
        n0 = nv_p;
        send(1, 11, 16'({1'b1, 1'b1, 8'h0F, 1'b0}), CPB_A);
        idle(CPB_A); #1;
        n_chk++; if (nv_p - n0 !== 1) $display("FAIL parity_bad_count got %0d exp 1", nv_p - n0); else n_pass++;
        n_chk++; if (lpe_p !== 1'b1) $display("FAIL parity_bad_perr got %b exp 1", lpe_p); else n_pass++;
        n_chk++; if (ld_p !== 8'h0F) $display("FAIL parity_bad_data got %h exp 0f", ld_p); else n_pass++;
        n_chk++; if (lfe_p !== 1'b0) $display("FAIL parity_bad_ferr got %b exp 0", lfe_p); else n_pass++;
        send(1, 11, 16'({1'b1, 1'b0, 8'h0F, 1'b0}), CPB_A);
        idle(CPB_A); #1;
        n_chk++; if (nv_p - n0 !== 2) $display("FAIL parity_good_count got %0d exp 2", nv_p - n0); else n_pass++;
        n_chk++; if (lpe_p !== 1'b0) $display("FAIL parity_good_perr got %b exp 0", lpe_p); else n_pass++;
    endtask

    task automatic test_glitch();
        int n0, b0;
        n0 = nv_a; b0 = busy_cyc_a;
        rx_a = 1'b0;
        idle(12);
        rx_a = 1'b1;
        idle(CPB_A); #1;
        n_chk++; if (nv_a - n0 !== 0) $display("FAIL glitch_count got %0d exp 0", nv_a - n0); else n_pass++;
        n_chk++; if ((busy_cyc_a > b0) !== 1'b1) $display("FAIL glitch_busy_pulse got %0d busy cycles exp >0", busy_cyc_a - b0); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL glitch_busy_after got %b exp 0", busy_a); else n_pass++;
    endtask

    task automatic test_break();
        int n0;
        n0 = nv_a;
        send(0, 10, 16'({1'b0, 8'h3C, 1'b0}), CPB_A);
        idle(20 * CPB_A); #1;
        n_chk++; if (nv_a - n0 !== 1) $display("FAIL break_count got %0d exp 1", nv_a - n0); else n_pass++;
        n_chk++; if (lfe_a !== 1'b1) $display("FAIL break_ferr got %b exp 1", lfe_a); else n_pass++;
        n_chk++; if (ld_a !== 8'h3C) $display("FAIL break_data got %h exp 3c", ld_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b1) $display("FAIL break_busy_wait got %b exp 1", busy_a); else n_pass++;
        rx_a = 1'b1;
        idle(CPB_A);
        send(0, 10, 16'({1'b1, 8'h55, 1'b0}), CPB_A);
        idle(CPB_A); #1;
        n_chk++; if (nv_a - n0 !== 2) $display("FAIL recover_count got %0d exp 2", nv_a - n0); else n_pass++;
        n_chk++; if (ld_a !== 8'h55) $display("FAIL recover_data got %h exp 55", ld_a); else n_pass++;
        n_chk++; if (lfe_a !== 1'b0) $display("FAIL recover_ferr got %b exp 0", lfe_a); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int n0;
        n0 = nv_a;
        // start bit plus data bits 0..3 of 0x81
        send(0, 5, 16'b0_0000_0000_0001_0, CPB_A); #1;
        n_chk++; if (busy_a !== 1'b1) $display("FAIL midreset_busy_before got %b exp 1", busy_a); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (data_a !== 8'h00) $display("FAIL midreset_data got %h exp 00", data_a); else n_pass++;
        n_chk++; if (valid_a !== 1'b0) $display("FAIL midreset_valid got %b exp 0", valid_a); else n_pass++;
        n_chk++; if (perr_a !== 1'b0 || ferr_a !== 1'b0) $display("FAIL midreset_err got %b%b exp 00", perr_a, ferr_a); else n_pass++;
        n_chk++; if (busy_a !== 1'b0) $display("FAIL midreset_busy got %b exp 0", busy_a); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        rx_a  = 1'b1;
        idle(CPB_A);
        send(0, 10, 16'({1'b1, 8'h81, 1'b0}), CPB_A);
        idle(CPB_A); #1;
        n_chk++; if (nv_a - n0 !== 1) $display("FAIL after_reset_count got %0d exp 1", nv_a - n0); else n_pass++;
        n_chk++; if (ld_a !== 8'h81) $display("FAIL after_reset_data got %h exp 81", ld_a); else n_pass++;
        n_chk++; if (lfe_a !== 1'b0 || lpe_a !== 1'b0) $display("FAIL after_reset_err got %b%b exp 00", lpe_a, lfe_a); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n0, e0;
        n0 = nv_b; e0 = err_cnt_b;
        send(2, 10, 16'({2'b11, 7'h12, 1'b0}), CPB_B);
        send(2, 10, 16'({2'b11, 7'h6E, 1'b0}), CPB_B);
        idle(2 * CPB_B); #1;
        n_chk++; if (nv_b - n0 !== 2) $display("FAIL b2b_count got %0d exp 2", nv_b - n0); else n_pass++;
        n_chk++; if (log_b[n0] !== 7'h12) $display("FAIL b2b_first got %h exp 12", log_b[n0]); else n_pass++;
        n_chk++; if (log_b[n0+1] !== 7'h6E) $display("FAIL b2b_second got %h exp 6e", log_b[n0+1]); else n_pass++;
        n_chk++; if (err_cnt_b - e0 !== 0) $display("FAIL b2b_errors got %0d exp 0", err_cnt_b - e0); else n_pass++;
        send(2, 10, 16'({1'b0, 1'b1, 7'h2A, 1'b0}), CPB_B);
        rx_b = 1'b1;
        idle(2 * CPB_B); #1;
        n_chk++; if (nv_b - n0 !== 3) $display("FAIL stop2_count got %0d exp 3", nv_b - n0); else n_pass++;
        n_chk++; if (lfe_b !== 1'b1) $display("FAIL stop2_ferr got %b exp 1", lfe_b); else n_pass++;
        n_chk++; if (log_b[n0+2] !== 7'h2A) $display("FAIL stop2_data got %h exp 2a", log_b[n0+2]); else n_pass++;
    endtask

    initial begin
        tick_b = 1'b1;
        reset  = 1'b1;
        rx_a = 1'b1; rx_p = 1'b1; rx_b = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
